// File: rtl/reg_bank_n.sv
// -----------------------------------------------------------------------------
// reg_bank_n
//   Instruction-driven register bank of REG_COUNT registers of DATA_WIDTH bits.
//   A single instruction word loads, clears, increments, decrements or copies a
//   register. One register, chosen by the most recent RDO instruction, is always
//   shown on out. An illegal opcode locks the bank in an Error state until the
//   next reset.
//
// Ports
//   clock    in   1                        single clock, all state on posedge
//   reset    in   1                        synchronous, active-high
//   inst     in   4+ADDR_WIDTH+DATA_WIDTH  {opcode[3:0], addr, imm}
//   inst_en  in   1                        inst is valid this cycle
//   out      out  DATA_WIDTH               reg[sel]; forced to 0 unless Ready
//   error    out  1                        high while in Error state
// -----------------------------------------------------------------------------
module reg_bank_n #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [4+ADDR_WIDTH+DATA_WIDTH-1:0] inst,
    input  logic                               inst_en,
    output logic [DATA_WIDTH-1:0]              out,
    output logic                               error
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_RDO = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_CLR = 4'h3;
    localparam logic [3:0] OP_INC = 4'h4;
    localparam logic [3:0] OP_DEC = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_CLA = 4'h7;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_READY = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   sel_reg;
    logic [ADDR_WIDTH-1:0]   sel_next;

    // Instruction fields
    logic [3:0]              opcode;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   imm;
    logic [ADDR_WIDTH-1:0]   src;

    assign opcode = inst[4+ADDR_WIDTH+DATA_WIDTH-1 -: 4];
    assign addr   = inst[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
    assign imm    = inst[DATA_WIDTH-1:0];
    assign src    = imm[ADDR_WIDTH-1:0];

    // exec:      a legal instruction is executed at this edge
    // wipe_all:  Reset/Error/illegal-state housekeeping, zeroes regs and sel
    // clear_all: CLA, zeroes regs but keeps sel
    logic exec;
    logic wipe_all;
    logic clear_all;

    // Register values gathered into one array for the output mux and MOV source
    logic [DATA_WIDTH-1:0]   reg_value [REG_COUNT];

    // -------------------------------------------------------------------------
    // Control: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_RESET;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
        end
    end

    // -------------------------------------------------------------------------
    // Control: next state, select and per-edge command flags
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        exec       = 1'b0;
        wipe_all   = 1'b0;
        clear_all  = 1'b0;
        case (state_reg)
            ST_RESET: begin
                // Single settling cycle; any instruction presented now is dropped.
                state_next = ST_READY;
                wipe_all   = 1'b1;
            end
            ST_READY: begin
                if (inst_en) begin
                    if (opcode[3]) begin
                        state_next = ST_ERROR;
                        wipe_all   = 1'b1;
                    end else begin
                        exec = 1'b1;
                        case (opcode)
                            OP_NOP:  ;
                            OP_RDO:  sel_next  = addr;
                            OP_CLA:  clear_all = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_ERROR: begin
                wipe_all = 1'b1;
            end
            default: begin
                // Unreachable encoding: treat as a fault.
                state_next = ST_ERROR;
                wipe_all   = 1'b1;
            end
        endcase
        if (wipe_all) begin
            sel_next = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: one slice per register; only the addressed slice reacts to a
    // single-register opcode.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic [DATA_WIDTH-1:0] value_next;
            logic                  hit;

            assign hit = exec && (addr == ADDR_WIDTH'(gi));

            always_comb begin
                value_next = value_reg;
                if (wipe_all || clear_all) begin
                    value_next = '0;
                end else if (hit) begin
                    case (opcode)
                        OP_LDR:  value_next = imm;
                        OP_CLR:  value_next = '0;
                        OP_INC:  value_next = value_reg + 1'b1;
                        OP_DEC:  value_next = value_reg - 1'b1;
                        // Self-copy reads the current value, so it is a no-op.
                        OP_MOV:  value_next = reg_value[src];
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    value_reg <= '0;
                end else begin
                    value_reg <= value_next;
                end
            end

            assign reg_value[gi] = value_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs: purely from registered state, never bypassed from inst.
    // Gating on Ready also hides any stale contents during an illegal state.
    // -------------------------------------------------------------------------
    assign out   = (state_reg == ST_READY) ? reg_value[sel_reg] : '0;
    assign error = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_reg_bank_n.sv
module tb_reg_bank_n;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int N  = 4;
    localparam int IW = 4 + AW + DW;

    localparam int PH_RST = 0;
    localparam int PH_RDY = 1;
    localparam int PH_ERR = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] inst = '0;
    logic          inst_en = 1'b0;
    logic [DW-1:0] out;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank_n #(
        .DATA_WIDTH (DW),
        .REG_COUNT  (N),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .out     (out),
        .error   (error)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Behavioural model: plain integer registers updated per clock edge
    // ------------------------------------------------------------------
    int m_regs [N];
    int m_sel   = 0;
    int m_phase = PH_RST;
    bit started = 1'b0;

    always @(posedge clock) begin
        int op, a, im;
        op = int'(inst[IW-1 -: 4]);
        a  = int'(inst[AW+DW-1 -: AW]);
        im = int'(inst[DW-1:0]);
        if (reset) begin
            started = 1'b1;
            m_phase = PH_RST;
            m_sel   = 0;
            for (int i = 0; i < N; i++) m_regs[i] = 0;
        end else if (started) begin
            if (m_phase == PH_RST) begin
                m_phase = PH_RDY;
            end else if (m_phase == PH_RDY && inst_en) begin
                if (op >= 8) begin
                    m_phase = PH_ERR;
                    m_sel   = 0;
                    for (int i = 0; i < N; i++) m_regs[i] = 0;
                end else begin
                    case (op)
                        1: m_sel = a;
                        2: m_regs[a] = im;
                        3: m_regs[a] = 0;
                        4: m_regs[a] = (m_regs[a] + 1) % 256;
                        5: m_regs[a] = (m_regs[a] + 255) % 256;
                        6: m_regs[a] = m_regs[im % N];
                        7: for (int i = 0; i < N; i++) m_regs[i] = 0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Compare process: every falling edge once a reset has been applied
    always @(negedge clock) begin
        int exp_out, exp_err;
        if (started) begin
            exp_out = (m_phase == PH_RDY) ? m_regs[m_sel] : 0;
            exp_err = (m_phase == PH_ERR) ? 1 : 0;
            n_checks++;
            if (int'(out) != exp_out) begin
                n_fail++;
                $display("FAIL model_out t=%0t got=%02h exp=%02h", $time, out, exp_out);
            end
            n_checks++;
            if (int'(error) != exp_err) begin
                n_fail++;
                $display("FAIL model_error t=%0t got=%0d exp=%0d", $time, error, exp_err);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Present one instruction (or idle) and advance one edge; returns at posedge+1.
    task automatic step(input logic [3:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] im, input logic en);
        inst    = {op, a, im};
        inst_en = en;
        @(posedge clock);
        #1;
        $display("step op=%h addr=%0d imm=%02h en=%0d reset=%0d -> out=%02h error=%0d",
                 op, a, im, en, reset, out, error);
    endtask

    task automatic idle();
        step(4'h0, '0, '0, 1'b0);
    endtask

    task automatic check_lit(input string name, input logic [DW-1:0] got_out,
                             input logic [DW-1:0] exp_out, input logic got_err,
                             input logic exp_err);
        n_checks++;
        if (got_out !== exp_out || got_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s got out=%02h error=%0d exp out=%02h error=%0d",
                     name, got_out, got_err, exp_out, exp_err);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // 1. Reset then idle
        reset = 1'b1;
        idle();
        reset = 1'b0;
        idle(); idle(); idle();
        check_lit("reset_idle", out, 8'h00, error, 1'b0);
        for (int a = 0; a < N; a++) begin
            step(4'h1, AW'(a), 8'h00, 1'b1);
            check_lit("reset_regs_zero", out, 8'h00, error, 1'b0);
        end

        // 2. Load, select, overwrite selected register
        step(4'h2, 2'd1, 8'hA5, 1'b1);
        step(4'h1, 2'd1, 8'h00, 1'b1);
        check_lit("rdo_after_ldr", out, 8'hA5, error, 1'b0);
        inst = {4'h2, 2'd1, 8'h3C}; inst_en = 1'b1; #1;
        check_lit("no_bypass", out, 8'hA5, error, 1'b0);
        step(4'h2, 2'd1, 8'h3C, 1'b1);
        check_lit("ldr_selected", out, 8'h3C, error, 1'b0);

        // 3. Wrap-around
        step(4'h2, 2'd0, 8'hFF, 1'b1);
        step(4'h1, 2'd0, 8'h00, 1'b1);
        check_lit("ldr_ff", out, 8'hFF, error, 1'b0);
        step(4'h4, 2'd0, 8'h00, 1'b1);
        check_lit("inc_wrap", out, 8'h00, error, 1'b0);
        step(4'h5, 2'd0, 8'h00, 1'b1);
        check_lit("dec_wrap", out, 8'hFF, error, 1'b0);
        step(4'h5, 2'd0, 8'h00, 1'b1);
        check_lit("dec_twice", out, 8'hFE, error, 1'b0);

        // 4. MOV
        step(4'h2, 2'd2, 8'h5A, 1'b1);
        step(4'h6, 2'd3, 8'h02, 1'b1);
        step(4'h1, 2'd3, 8'h00, 1'b1);
        check_lit("mov_dst", out, 8'h5A, error, 1'b0);
        step(4'h1, 2'd2, 8'h00, 1'b1);
        check_lit("mov_src_kept", out, 8'h5A, error, 1'b0);
        step(4'h6, 2'd1, 8'hF2, 1'b1);   // upper imm bits ignored
        step(4'h1, 2'd1, 8'h00, 1'b1);
        check_lit("mov_upper_imm", out, 8'h5A, error, 1'b0);
        step(4'h6, 2'd1, 8'h01, 1'b1);   // self copy
        check_lit("mov_self", out, 8'h5A, error, 1'b0);

        // 5. CLA keeps sel
        step(4'h2, 2'd0, 8'h11, 1'b1);
        step(4'h2, 2'd2, 8'h22, 1'b1);
        step(4'h1, 2'd2, 8'h00, 1'b1);
        check_lit("pre_cla", out, 8'h22, error, 1'b0);
        step(4'h7, 2'd0, 8'h00, 1'b1);
        check_lit("cla", out, 8'h00, error, 1'b0);
        step(4'h2, 2'd2, 8'h77, 1'b1);
        check_lit("cla_sel_kept", out, 8'h77, error, 1'b0);
        step(4'h1, 2'd0, 8'h00, 1'b1);
        check_lit("cla_reg0", out, 8'h00, error, 1'b0);

        // 6. Illegal opcode, sticky error, recovery
        step(4'h2, 2'd0, 8'h44, 1'b1);
        step(4'h9, 2'd0, 8'h00, 1'b1);
        check_lit("illegal", out, 8'h00, error, 1'b1);
        step(4'h2, 2'd0, 8'h11, 1'b1);
        check_lit("error_sticky", out, 8'h00, error, 1'b1);
        idle();
        check_lit("error_sticky_idle", out, 8'h00, error, 1'b1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        check_lit("error_reset", out, 8'h00, error, 1'b0);
        idle();
        check_lit("ready_after_error", out, 8'h00, error, 1'b0);
        step(4'h2, 2'd0, 8'h11, 1'b1);
        check_lit("ldr_after_recovery", out, 8'h11, error, 1'b0);

        // 7. reset beats inst_en; instruction in Reset cycle ignored
        reset = 1'b1;
        step(4'h2, 2'd0, 8'h77, 1'b1);
        reset = 1'b0;
        step(4'h2, 2'd0, 8'h77, 1'b1);
        idle();
        check_lit("reset_priority", out, 8'h00, error, 1'b0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] op;
            int r;
            r  = int'($urandom_range(0, 99));
            op = (r < 2) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            reset = ($urandom_range(0, 59) == 0);
            step(op, AW'($urandom_range(0, N - 1)), DW'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        reset = 1'b0;
        idle();

        @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
